// File: rtl/esm_pkg.sv
// Shared types and helpers for the ESM issue arbiter.
package esm_pkg;

  localparam int unsigned INSTR_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_STALL = 2'd2
  } state_t;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request after last_grant, wrapping.
module rr_arbiter
  import esm_pkg::*;
#(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  input  logic          en,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic          found;
  logic [IW-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = IW'((32'(last_grant) + k) % N);
      if (en && !found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/esm_issue_arbiter.sv
// Round-robin issue arbiter in front of ESM with credit-based flow control.
module esm_issue_arbiter
  import esm_pkg::*;
#(
  parameter  int unsigned INSTR_W   = INSTR_W_DEF,
  parameter  int unsigned N_REQ     = 4,
  parameter  int unsigned ESM_DEPTH = 16,
  localparam int unsigned CW        = clog2(ESM_DEPTH + 1),
  localparam int unsigned IW        = clog2(N_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*INSTR_W-1:0] req_instr,
  output logic [N_REQ-1:0]         req_ready,
  output logic [INSTR_W-1:0]       esm_instr,
  output logic                     esm_valid,
  input  logic                     esm_retire,
  output logic [CW-1:0]            credits,
  output logic [1:0]               state,
  output logic                     overflow_err
);

  logic [IW-1:0]      last_grant;
  logic [IW-1:0]      grant_idx;
  logic [N_REQ-1:0]   grant;
  logic [INSTR_W-1:0] sel_word;
  logic               has_credit;
  logic               full;
  logic               issue;
  state_t             st;
  state_t             st_nxt;

  assign has_credit = (credits != '0);
  assign full       = (credits == CW'(ESM_DEPTH));
  assign issue      = |grant;
  assign req_ready  = grant;
  assign state      = st;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .req        (req_valid),
    .last_grant (last_grant),
    .en         (has_credit),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  // Word of the granted requester (grant is one-hot).
  always_comb begin
    sel_word = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant[i]) sel_word = req_instr[i*INSTR_W +: INSTR_W];
    end
  end

  always_comb begin
    st_nxt = ST_IDLE;
    if (|req_valid) st_nxt = has_credit ? ST_ISSUE : ST_STALL;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st           <= ST_IDLE;
      last_grant   <= IW'(N_REQ - 1);
      esm_instr    <= '0;
      esm_valid    <= 1'b0;
      credits      <= CW'(ESM_DEPTH);
      overflow_err <= 1'b0;
    end else begin
      st        <= st_nxt;
      esm_valid <= issue;
      if (issue) begin
        last_grant <= grant_idx;
        esm_instr  <= sel_word;
      end
      // Issue and retire in the same cycle cancel out.
      case ({issue, esm_retire})
        2'b10:   credits <= credits - CW'(1);
        2'b01: begin
          if (full) overflow_err <= 1'b1;
          else      credits      <= credits + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_esm_issue_arbiter.sv
// Self-checking bench for esm_issue_arbiter: vector table, corner sequences, random vs model.
module tb_esm_issue_arbiter;

  localparam int N = 4;
  localparam int D = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [63:0] req_instr = '0;
  logic [3:0]  req_ready;
  logic [15:0] esm_instr;
  logic        esm_valid;
  logic        esm_retire = 1'b0;
  logic [4:0]  credits;
  logic [1:0]  state;
  logic        overflow_err;

  always #5 clk = ~clk;

  esm_issue_arbiter #(.INSTR_W(16), .N_REQ(4), .ESM_DEPTH(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_instr    (req_instr),
    .req_ready    (req_ready),
    .esm_instr    (esm_instr),
    .esm_valid    (esm_valid),
    .esm_retire   (esm_retire),
    .credits      (credits),
    .state        (state),
    .overflow_err (overflow_err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: free slots, last granted requester, last registered outputs.
  int          m_cred;
  int          m_last;
  int          m_state;
  logic        m_ev;
  logic        m_ovf;
  logic [15:0] m_instr;
  logic [3:0]  s_ready;

  typedef struct {
    logic        rst_before;
    logic [3:0]  v;
    logic [15:0] w0;
    logic        r;
    logic [3:0]  rdy;
    logic        ev;
    logic [15:0] ins;
    logic [4:0]  cr;
    logic [1:0]  st;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int m_pick(input logic [3:0] v);
    if (m_cred == 0) return -1;
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (m_last + k) % N;
      if (v[i[1:0]]) return i;
    end
    return -1;
  endfunction

  function automatic vec_t mk(input logic rb, input logic [3:0] v, input logic [15:0] w0,
                              input logic r, input logic [3:0] rdy, input logic ev,
                              input logic [15:0] ins, input logic [4:0] cr, input logic [1:0] st);
    vec_t t;
    t.rst_before = rb; t.v = v; t.w0 = w0; t.r = r; t.rdy = rdy;
    t.ev = ev; t.ins = ins; t.cr = cr; t.st = st;
    return t;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; req_valid = '0; req_instr = '0; esm_retire = 1'b0;
    #3;
    m_cred = D; m_last = N - 1; m_state = 0; m_ev = 1'b0; m_ovf = 1'b0; m_instr = '0;
    chk("rst_credits", 32'(credits), 32'd16);
    chk("rst_esm_valid", 32'(esm_valid), 32'd0);
    chk("rst_esm_instr", 32'(esm_instr), 32'd0);
    chk("rst_overflow", 32'(overflow_err), 32'd0);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic step(input logic [3:0] v, input logic [63:0] words, input logic r);
    int g;
    logic [3:0] er;
    @(negedge clk);
    req_valid = v; req_instr = words; esm_retire = r;
    #1;
    g  = m_pick(v);
    er = (g < 0) ? 4'b0 : 4'(1 << g);
    s_ready = req_ready;
    chk("req_ready", 32'(req_ready), 32'(er));
    @(posedge clk);
    m_state = (v == 4'b0) ? 0 : ((m_cred > 0) ? 1 : 2);
    if (g >= 0) begin
      m_last = g; m_instr = 16'(words >> (16 * g)); m_ev = 1'b1;
    end else begin
      m_ev = 1'b0;
    end
    if (g >= 0 && !r) m_cred--;
    else if (g < 0 && r) begin
      if (m_cred == D) m_ovf = 1'b1;
      else m_cred++;
    end
    #1;
    chk("esm_valid", 32'(esm_valid), 32'(m_ev));
    chk("esm_instr", 32'(esm_instr), 32'(m_instr));
    chk("credits", 32'(credits), 32'(m_cred));
    chk("state", 32'(state), 32'(m_state));
    chk("overflow_err", 32'(overflow_err), 32'(m_ovf));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] wfix;
    int issues;
    wfix = 64'hA003_A002_A001_0001;

    tbl[0]  = mk(1, 4'h1, 16'h0001, 0, 4'h1, 1, 16'h0001, 5'd15, 2'd1);
    tbl[1]  = mk(0, 4'h1, 16'h0002, 0, 4'h1, 1, 16'h0002, 5'd14, 2'd1);
    tbl[2]  = mk(0, 4'h1, 16'h0003, 0, 4'h1, 1, 16'h0003, 5'd13, 2'd1);
    tbl[3]  = mk(0, 4'h1, 16'h0004, 0, 4'h1, 1, 16'h0004, 5'd12, 2'd1);
    tbl[4]  = mk(0, 4'h1, 16'h0005, 0, 4'h1, 1, 16'h0005, 5'd11, 2'd1);
    tbl[5]  = mk(0, 4'h0, 16'h0006, 0, 4'h0, 0, 16'h0005, 5'd11, 2'd0);
    tbl[6]  = mk(1, 4'hF, 16'hA000, 0, 4'h1, 1, 16'hA000, 5'd15, 2'd1);
    tbl[7]  = mk(0, 4'hF, 16'hA000, 0, 4'h2, 1, 16'hA001, 5'd14, 2'd1);
    tbl[8]  = mk(0, 4'hF, 16'hA000, 0, 4'h4, 1, 16'hA002, 5'd13, 2'd1);
    tbl[9]  = mk(0, 4'hF, 16'hA000, 0, 4'h8, 1, 16'hA003, 5'd12, 2'd1);
    tbl[10] = mk(0, 4'hF, 16'hA000, 0, 4'h1, 1, 16'hA000, 5'd11, 2'd1);
    tbl[11] = mk(0, 4'h0, 16'hA000, 0, 4'h0, 0, 16'hA000, 5'd11, 2'd0);
    tbl[12] = mk(0, 4'hA, 16'hA000, 0, 4'h2, 1, 16'hA001, 5'd10, 2'd1);
    tbl[13] = mk(0, 4'hA, 16'hA000, 0, 4'h8, 1, 16'hA003, 5'd9,  2'd1);
    tbl[14] = mk(0, 4'h0, 16'hA000, 1, 4'h0, 0, 16'hA003, 5'd10, 2'd0);
    tbl[15] = mk(0, 4'h4, 16'hA000, 1, 4'h4, 1, 16'hA002, 5'd10, 2'd1);

    do_reset();
    repeat (2) step(4'h0, 64'h0, 1'b0);
    chk("idle_req_ready", 32'(s_ready), 32'd0);
    chk("idle_credits", 32'(credits), 32'd16);

    for (int i = 0; i < 16; i++) begin
      if (tbl[i].rst_before) do_reset();
      step(tbl[i].v, {16'hA003, 16'hA002, 16'hA001, tbl[i].w0}, tbl[i].r);
      chk($sformatf("tbl%0d_ready", i), 32'(s_ready), 32'(tbl[i].rdy));
      chk($sformatf("tbl%0d_valid", i), 32'(esm_valid), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d_instr", i), 32'(esm_instr), 32'(tbl[i].ins));
      chk($sformatf("tbl%0d_credits", i), 32'(credits), 32'(tbl[i].cr));
      chk($sformatf("tbl%0d_state", i), 32'(state), 32'(tbl[i].st));
    end

    // Credit exhaustion and single-retire recovery.
    do_reset();
    repeat (16) step(4'h1, wfix, 1'b0);
    chk("exh_credits", 32'(credits), 32'd0);
    step(4'h1, wfix, 1'b0);
    chk("exh_ready", 32'(s_ready), 32'd0);
    chk("exh_state", 32'(state), 32'd2);
    chk("exh_valid", 32'(esm_valid), 32'd0);
    step(4'h1, wfix, 1'b1);
    chk("exh_ret_ready", 32'(s_ready), 32'd0);
    chk("exh_ret_credits", 32'(credits), 32'd1);
    step(4'h1, wfix, 1'b0);
    chk("exh_resume_ready", 32'(s_ready), 32'd1);
    chk("exh_resume_valid", 32'(esm_valid), 32'd1);
    chk("exh_resume_credits", 32'(credits), 32'd0);
    step(4'h1, wfix, 1'b0);
    chk("exh_restall_valid", 32'(esm_valid), 32'd0);
    chk("exh_restall_state", 32'(state), 32'd2);

    // Simultaneous issue and retire hold credits steady.
    repeat (5) step(4'h0, wfix, 1'b1);
    chk("sim_start_credits", 32'(credits), 32'd5);
    issues = 0;
    repeat (4) begin
      step(4'h1, wfix, 1'b1);
      if (esm_valid === 1'b1) issues++;
    end
    chk("sim_credits", 32'(credits), 32'd5);
    chk("sim_issues", 32'(issues), 32'd4);

    // Overflow is sticky until reset; issue+retire at full is legal.
    do_reset();
    step(4'h0, wfix, 1'b1);
    chk("ovf_credits", 32'(credits), 32'd16);
    chk("ovf_flag", 32'(overflow_err), 32'd1);
    repeat (3) step(4'h2, wfix, 1'b0);
    chk("ovf_sticky", 32'(overflow_err), 32'd1);
    do_reset();
    step(4'h1, wfix, 1'b1);
    chk("full_ir_credits", 32'(credits), 32'd16);
    chk("full_ir_flag", 32'(overflow_err), 32'd0);

    // Random traffic: first drain-biased, then fill-biased retire rate.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      logic [3:0]  v;
      logic [63:0] w;
      logic        r;
      v = 4'($urandom_range(0, 15));
      w = {$urandom, $urandom};
      r = (n < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      step(v, w, r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
